// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead byte FIFO and sticky error flags.
// Define UART_RX_OVERRUN_CNT_EN to add a saturating dropped-byte counter on overrun_cnt.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             bus_clk,
  input  logic             bus_reset_l,
  input  logic             ser_rx,
  input  logic [31:0]      div,
  input  logic             rd_en,
  input  logic             clr,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             frame_err,
  output logic             overrun,
  output logic [15:0]      overrun_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  logic        rx_meta_q, rx_s_q;
  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        push, ferr_set;
  logic [31:0] d_eff, full_rl, half_rl;
  logic        tick;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
  logic        fifo_full, pop, push_ok, drop;
  logic        frame_err_q, frame_err_d, overrun_q, overrun_d;

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= ser_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign d_eff   = (div < 32'd4) ? 32'd4 : div;
  assign full_rl = d_eff - 32'd1;
  assign half_rl = (d_eff >> 1) - 32'd1;
  assign tick    = (tmr_q == 32'd0);

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rx_s_q) state_d = S_START;
      S_START:     if (tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:      if (tick && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:      if (tick) state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Timer idles at 0 once expired; every active state reloads it on the tick it consumes.
  always_comb begin
    tmr_d    = tick ? tmr_q : tmr_q - 32'd1;
    shift_d  = shift_q;
    idx_d    = idx_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: if (!rx_s_q) tmr_d = half_rl;
      S_START: begin
        if (tick && !rx_s_q) begin
          tmr_d = full_rl;
          idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          tmr_d   = full_rl;
        end
      end
      S_STOP: begin
        if (tick) begin
          push     = rx_s_q;
          ferr_set = !rx_s_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      tmr_q   <= 32'd0;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
    end else begin
      tmr_q   <= tmr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign fifo_full = (occ == (AW+1)'(DEPTH));
  assign rd_valid  = (occ != '0);
  assign pop       = rd_en && rd_valid;
  assign push_ok   = push && (!fifo_full || pop);
  assign drop      = push && !push_ok;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    frame_err_d = frame_err_q | ferr_set;
    overrun_d   = overrun_q | drop;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge bus_clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign rd_data   = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign count     = CNT_W'(occ);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (clr)                                 ovr_cnt_d = 16'h0000;
    else if (drop && ovr_cnt_q != 16'hFFFF)  ovr_cnt_d = ovr_cnt_q + 16'h0001;
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) ovr_cnt_q <= 16'h0000;
    else              ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 16'h0000;
`endif

endmodule
